free_list: RTL and testbench

Circular FIFO of free physical register tags feeding the rename stage: supplies one new destination tag per dispatch slot to the map table and accepts old tags back from the ROB at commit. It holds the `PHYS_REGS - ARCH_REGS` tags not in the identity reset mapping. It saves its head pointer alongside each map-table checkpoint so that branch recovery and full flush reclaim wrong-path allocations in one cycle.

---
 rtl/sys_defs.sv | 18 +
 rtl/fl_prefix_count.sv | 24 ++
 rtl/free_list.sv | 118 +++++++++++
 tb/tb_free_list.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared rename-stage configuration: register-file sizes, free-list geometry
// and the tag/pointer types used by the free list and the map table.
package sys_defs;

    localparam int ARCH_REGS_DEF      = 64;
    localparam int PHYS_REGS_DEF      = 128;
    localparam int DISPATCH_WIDTH_DEF = 1;
    localparam int COMMIT_WIDTH_DEF   = 1;
    localparam int CKPT_DEPTH_DEF     = 4;

    localparam int FL_SIZE    = PHYS_REGS_DEF - ARCH_REGS_DEF;
    localparam int FL_PTR_W   = $clog2(FL_SIZE) + 1;
    localparam int PHYS_TAG_W = $clog2(PHYS_REGS_DEF);

    typedef logic [FL_PTR_W-1:0]   fl_ptr_t;
    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

endpackage

// File: rtl/fl_prefix_count.sv
// Exclusive prefix popcount of a request vector plus its total; used both to
// compact commit slots onto consecutive tail entries and to advance pointers.
module fl_prefix_count #(
    parameter int N     = 1,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]            bits,
    output logic [N-1:0][CNT_W-1:0] offset,
    output logic [CNT_W-1:0]        total
);

    logic [CNT_W-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < N; i++) begin
            offset[i] = acc;
            acc       = acc + CNT_W'(bits[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical tags for rename. Head is checkpointed per
// branch so recovery and flush reclaim wrong-path allocations in one cycle.
module free_list
    import sys_defs::*;
#(
    parameter int ARCH_REGS      = ARCH_REGS_DEF,
    parameter int PHYS_REGS      = PHYS_REGS_DEF,
    parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEF,
    parameter int COMMIT_WIDTH   = COMMIT_WIDTH_DEF,
    parameter int CKPT_DEPTH     = CKPT_DEPTH_DEF
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [DISPATCH_WIDTH-1:0]                        disp_valid_i,
    output logic [DISPATCH_WIDTH-1:0][$clog2(PHYS_REGS)-1:0] alloc_phys_o,
    output logic                                             alloc_stall_o,
    output logic [$clog2(PHYS_REGS-ARCH_REGS):0]             free_count_o,
    input  logic [COMMIT_WIDTH-1:0]                          commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]   commit_old_phys_i,
    input  logic                                             ckpt_save_i,
    input  logic [$clog2(CKPT_DEPTH)-1:0]                    ckpt_id_i,
    input  logic                                             restore_valid_i,
    input  logic [$clog2(CKPT_DEPTH)-1:0]                    restore_id_i,
    input  logic                                             flush_i
);

    // LIST_SIZE must be a power of two: pointer wrap relies on modulo 2^PTR_W.
    localparam int LIST_SIZE = PHYS_REGS - ARCH_REGS;
    localparam int IDX_W     = $clog2(LIST_SIZE);
    localparam int PTR_W     = IDX_W + 1;
    localparam int TAG_W     = $clog2(PHYS_REGS);
    localparam int DCNT_W    = $clog2(DISPATCH_WIDTH + 1);
    localparam int CCNT_W    = $clog2(COMMIT_WIDTH + 1);

    logic [TAG_W-1:0] entry_mem [LIST_SIZE];
    logic [PTR_W-1:0] ckpt_reg  [CKPT_DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W-1:0] count;

    logic [DISPATCH_WIDTH-1:0][DCNT_W-1:0] disp_offset;
    logic [DCNT_W-1:0]                     disp_total;
    logic [DCNT_W-1:0]                     alloc_taken;
    logic [COMMIT_WIDTH-1:0][CCNT_W-1:0]   commit_offset;
    logic [CCNT_W-1:0]                     commit_total;
    logic [COMMIT_WIDTH-1:0][IDX_W-1:0]    wr_idx;

    fl_prefix_count #(.N(DISPATCH_WIDTH), .CNT_W(DCNT_W)) u_disp_count (
        .bits   (disp_valid_i),
        .offset (disp_offset),
        .total  (disp_total)
    );

    fl_prefix_count #(.N(COMMIT_WIDTH), .CNT_W(CCNT_W)) u_commit_count (
        .bits   (commit_valid_i),
        .offset (commit_offset),
        .total  (commit_total)
    );

    assign count         = tail_reg - head_reg;
    assign free_count_o  = count;
    assign alloc_stall_o = (count < PTR_W'(DISPATCH_WIDTH));

    // Slot i always peeks head+i; requests must therefore be packed from slot 0.
    for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_alloc
        logic [IDX_W-1:0] peek_idx;
        assign peek_idx         = head_reg[IDX_W-1:0] + IDX_W'(gi);
        assign alloc_phys_o[gi] = entry_mem[peek_idx];

        a_packed_request: assert property (@(posedge clock) disable iff (reset)
            (alloc_taken != '0 && disp_valid_i[gi]) |-> (disp_offset[gi] == DCNT_W'(gi)));
    end

    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_commit
        assign wr_idx[gi] = tail_reg[IDX_W-1:0] + IDX_W'(commit_offset[gi]);
    end

    always_comb begin
        alloc_taken = (alloc_stall_o || flush_i || restore_valid_i) ? '0 : disp_total;
        tail_next   = tail_reg + PTR_W'(commit_total);
        head_next   = head_reg + PTR_W'(alloc_taken);
        if (flush_i) begin
            head_next = {~tail_next[PTR_W-1], tail_next[IDX_W-1:0]};
        end else if (restore_valid_i) begin
            head_next = ckpt_reg[restore_id_i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= PTR_W'(LIST_SIZE);
            for (int k = 0; k < CKPT_DEPTH; k++) begin
                ckpt_reg[k] <= '0;
            end
            for (int k = 0; k < LIST_SIZE; k++) begin
                entry_mem[k] <= TAG_W'(ARCH_REGS + k);
            end
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            if (ckpt_save_i) begin
                ckpt_reg[ckpt_id_i] <= head_next;
            end
            for (int c = 0; c < COMMIT_WIDTH; c++) begin
                if (commit_valid_i[c]) begin
                    entry_mem[wr_idx[c]] <= commit_old_phys_i[c];
                end
            end
        end
    end

    // Returning more tags than are outstanding would corrupt live entries.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset || flush_i || restore_valid_i)
        (int'(count) + int'(commit_total) - int'(alloc_taken) <= LIST_SIZE));

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed rename scenarios on a 1-wide instance and a
// randomized alloc/commit run with a tag scoreboard on a 2-wide instance.
module tb_free_list;
    import sys_defs::*;

    logic clock;
    logic r1, r2;

    logic [0:0]      d1_dv, d1_cv;
    phys_tag_t [0:0] d1_alloc, d1_ctag;
    logic            d1_stall, d1_save, d1_rv, d1_fl;
    fl_ptr_t         d1_cnt;
    logic [1:0]      d1_sid, d1_rid;

    logic [1:0]      d2_dv, d2_cv;
    phys_tag_t [1:0] d2_alloc, d2_ctag;
    logic            d2_stall, d2_save, d2_rv, d2_fl;
    fl_ptr_t         d2_cnt;
    logic [1:0]      d2_sid, d2_rid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: unbounded head/tail counters over a 64-entry ring.
    int m_mem  [2][64];
    int m_head [2];
    int m_tail [2];
    int m_ckpt [2][4];
    int m_dw   [2];

    bit outst [128];
    int outq [$];

    free_list #(.DISPATCH_WIDTH(1), .COMMIT_WIDTH(1)) u_fl1 (
        .clock(clock), .reset(r1), .disp_valid_i(d1_dv), .alloc_phys_o(d1_alloc),
        .alloc_stall_o(d1_stall), .free_count_o(d1_cnt), .commit_valid_i(d1_cv),
        .commit_old_phys_i(d1_ctag), .ckpt_save_i(d1_save), .ckpt_id_i(d1_sid),
        .restore_valid_i(d1_rv), .restore_id_i(d1_rid), .flush_i(d1_fl)
    );

    free_list #(.DISPATCH_WIDTH(2), .COMMIT_WIDTH(2)) u_fl2 (
        .clock(clock), .reset(r2), .disp_valid_i(d2_dv), .alloc_phys_o(d2_alloc),
        .alloc_stall_o(d2_stall), .free_count_o(d2_cnt), .commit_valid_i(d2_cv),
        .commit_old_phys_i(d2_ctag), .ckpt_save_i(d2_save), .ckpt_id_i(d2_sid),
        .restore_valid_i(d2_rv), .restore_id_i(d2_rid), .flush_i(d2_fl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int d, input logic [1:0] dv, input logic [1:0] cv,
                              input int t0, input int t1, input logic sv, input int sid,
                              input logic rv, input int rid, input logic fl, input logic rst);
        int k, tn, hn;
        if (rst) begin
            m_head[d] = 0;
            m_tail[d] = 64;
            for (int j = 0; j < 64; j++) m_mem[d][j] = 64 + j;
            for (int j = 0; j < 4; j++) m_ckpt[d][j] = 0;
            return;
        end
        k = 0;
        if (cv[0]) begin m_mem[d][m_tail[d] % 64] = t0; k++; end
        if (cv[1]) begin m_mem[d][(m_tail[d] + k) % 64] = t1; k++; end
        tn = m_tail[d] + k;
        if (fl)                                     hn = tn - 64;
        else if (rv)                                hn = m_ckpt[d][rid];
        else if (m_tail[d] - m_head[d] < m_dw[d])   hn = m_head[d];
        else                                        hn = m_head[d] + int'(dv[0]) + int'(dv[1]);
        if (sv) m_ckpt[d][sid] = hn;
        m_head[d] = hn;
        m_tail[d] = tn;
    endtask

    task automatic tick();
        model_step(0, {1'b0, d1_dv}, {1'b0, d1_cv}, int'(d1_ctag[0]), 0, d1_save, int'(d1_sid),
                   d1_rv, int'(d1_rid), d1_fl, r1);
        model_step(1, d2_dv, d2_cv, int'(d2_ctag[0]), int'(d2_ctag[1]), d2_save, int'(d2_sid),
                   d2_rv, int'(d2_rid), d2_fl, r2);
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        d1_dv = '0; d1_cv = '0; d1_ctag = '0; d1_save = 0; d1_sid = '0;
        d1_rv = 0; d1_rid = '0; d1_fl = 0;
        d2_dv = '0; d2_cv = '0; d2_ctag = '0; d2_save = 0; d2_sid = '0;
        d2_rv = 0; d2_rid = '0; d2_fl = 0;
    endtask

    task automatic check_dut(input int d);
        int cnt;
        cnt = m_tail[d] - m_head[d];
        if (d == 0) begin
            check("fl1_count", d1_cnt, cnt);
            check("fl1_stall", d1_stall, (cnt < 1));
            check("fl1_tag0", d1_alloc[0], m_mem[0][m_head[0] % 64]);
        end else begin
            check("fl2_count", d2_cnt, cnt);
            check("fl2_stall", d2_stall, (cnt < 2));
            check("fl2_tag0", d2_alloc[0], m_mem[1][m_head[1] % 64]);
            check("fl2_tag1", d2_alloc[1], m_mem[1][(m_head[1] + 1) % 64]);
        end
    endtask

    initial begin
        int nalloc, ncom, cnt, pick;
        int new_tags [$];

        m_dw[0] = 1;
        m_dw[1] = 2;
        clr();
        r1 = 1; r2 = 1;
        tick();
        tick();
        r1 = 0; r2 = 0;

        check_dut(0);
        check_dut(1);
        check("reset_count", d1_cnt, 64);
        check("reset_tag", d1_alloc[0], 64);
        check("reset_stall", d1_stall, 0);
        check("reset_tag1_w2", d2_alloc[1], 65);

        // Drain all 64 tags one per cycle.
        for (int i = 0; i < 64; i++) begin
            check("drain_tag", d1_alloc[0], 64 + i);
            d1_dv = 1'b1;
            tick();
            check_dut(0);
        end
        d1_dv = 1'b0;
        check("empty_count", d1_cnt, 0);
        check("empty_stall", d1_stall, 1);
        d1_dv = 1'b1;
        tick();
        d1_dv = 1'b0;
        check("stalled_count", d1_cnt, 0);
        check_dut(0);

        // Return 5 then 9; they come back out in that order.
        d1_cv = 1'b1; d1_ctag[0] = 7'd5;
        tick();
        d1_ctag[0] = 7'd9;
        tick();
        d1_cv = 1'b0;
        check("commit_count", d1_cnt, 2);
        check("realloc_first", d1_alloc[0], 5);
        d1_dv = 1'b1;
        tick();
        check("realloc_second", d1_alloc[0], 9);
        tick();
        d1_dv = 1'b0;
        check_dut(0);

        // Reset with every other input active.
        r1 = 1; d1_dv = 1'b1; d1_cv = 1'b1; d1_ctag[0] = 7'd3; d1_fl = 1; d1_rv = 1;
        tick();
        r1 = 0;
        clr();
        check("midreset_count", d1_cnt, 64);
        check("midreset_tag", d1_alloc[0], 64);
        check_dut(0);

        // Checkpoint saved alongside the 10th allocation records head 10.
        d1_dv = 1'b1;
        repeat (9) tick();
        d1_save = 1; d1_sid = 2'd2;
        tick();
        d1_save = 0;
        repeat (3) tick();
        d1_dv = 1'b0;
        check("pre_restore_count", d1_cnt, 51);
        d1_rv = 1; d1_rid = 2'd2; d1_dv = 1'b1;
        tick();
        clr();
        check("restore_count", d1_cnt, 54);
        check("restore_tag", d1_alloc[0], 74);
        check_dut(0);

        // Restore together with a commit of tag 77.
        d1_dv = 1'b1;
        repeat (5) tick();
        d1_dv = 1'b0; d1_save = 1; d1_sid = 2'd1;
        tick();
        d1_save = 0; d1_dv = 1'b1;
        repeat (2) tick();
        d1_rv = 1; d1_rid = 2'd1; d1_cv = 1'b1; d1_ctag[0] = 7'd77;
        tick();
        clr();
        check("restore_commit_count", d1_cnt, 50);
        for (int i = 0; i < 49; i++) begin
            check("reinstated_tag", d1_alloc[0], 79 + i);
            d1_dv = 1'b1;
            tick();
        end
        d1_dv = 1'b0;
        check("late_commit_tag", d1_alloc[0], 77);
        check("late_commit_count", d1_cnt, 1);
        d1_dv = 1'b1;
        tick();
        d1_dv = 1'b0;
        check_dut(0);

        // Flush wins over restore and allocation; its commit still lands.
        d1_fl = 1; d1_rv = 1; d1_rid = 2'd2; d1_dv = 1'b1; d1_cv = 1'b1; d1_ctag[0] = 7'd100;
        tick();
        clr();
        check("flush_count", d1_cnt, 64);
        check("flush_stall", d1_stall, 0);
        check("flush_tag", d1_alloc[0], 66);
        check_dut(0);

        // Randomized 2-wide alloc/commit with an outstanding-tag scoreboard.
        for (int cyc = 0; cyc < 200; cyc++) begin
            check_dut(1);
            check("sb_count", d2_cnt, 64 - outq.size());
            cnt = m_tail[1] - m_head[1];
            nalloc = (cnt < 2) ? 0 : int'($urandom_range(0, 2));
            d2_dv = (nalloc == 0) ? 2'b00 : ((nalloc == 1) ? 2'b01 : 2'b11);
            new_tags.delete();
            for (int i = 0; i < nalloc; i++) begin
                check("sb_dup", outst[d2_alloc[i]], 0);
                new_tags.push_back(m_mem[1][(m_head[1] + i) % 64]);
            end
            ncom = int'($urandom_range(0, (outq.size() < 2) ? outq.size() : 2));
            d2_cv = '0;
            for (int j = 0; j < ncom; j++) begin
                pick = int'($urandom_range(0, outq.size() - 1));
                d2_ctag[j] = phys_tag_t'(outq[pick]);
                outq.delete(pick);
                outst[d2_ctag[j]] = 0;
                d2_cv[j] = 1'b1;
            end
            foreach (new_tags[i]) begin
                outst[new_tags[i]] = 1;
                outq.push_back(new_tags[i]);
            end
            tick();
        end
        clr();
        check_dut(1);
        check("sb_final_count", d2_cnt, 64 - outq.size());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
